axil_slave_mem: RTL and testbench
=================================

Name: axil_slave_mem

Overview:
AXI-Lite slave (responder) that terminates the CPU master's five AXI-Lite channels and backs them with a word-addressed on-chip memory.
- Sits on the SoC AXI-Lite bus as the memory target, alongside the AXI-to-SPI bridge.
- Read and write paths are fully independent FSMs.
- Out-of-range accesses return SLVERR.
- A configurable wait-state count exercises master-side stall handling.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (32 or 64)
DEPTH, 256, number of DATA_WIDTH words in memory
BASE_ADDR, 32'h0000_0000, byte address of word 0
WAIT_CYCLES, 0, extra cycles inserted before BVALID/RVALID (0..15)

Ports:
clk  in  1  clock
rstn  in  1  reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. On reset:
  - AWREADY=WREADY=ARREADY=0 and BVALID=RVALID=0 in the reset cycle; BRESP=RRESP=2'b00; RDATA=0.
  - All FSMs return to idle; in-flight transactions are dropped with no response.
  - Memory contents are not reset.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AWREADY=1 until AW is captured, WREADY=1 until W is captured.
  - AW and W are accepted in either order or in the same cycle. Each is latched on its VALID&&READY.
  - When both are held: decode, commit the write to memory if in range, load the wait counter = WAIT_CYCLES, go to W_WAIT (or straight to W_RESP if WAIT_CYCLES=0).
  - W_WAIT: decrement the counter each cycle; go to W_RESP when it reaches 0.
  - W_RESP: BVALID=1. BRESP=2'b00 (OKAY) or 2'b10 (SLVERR), held stable until BREADY. On BVALID&&BREADY go to W_IDLE in the next cycle; AWREADY/WREADY reassert there.
  - Minimum latency, last of AW/W handshake to BVALID high: 1 cycle + WAIT_CYCLES.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY latch ARADDR, deassert ARREADY.
  - After WAIT_CYCLES, enter R_DATA. RDATA is registered from memory on the entry edge. RVALID=1 with RDATA/RRESP held stable until RREADY.
  - On RVALID&&RREADY return to R_IDLE.
  - Minimum latency, AR handshake to RVALID: 1 cycle + WAIT_CYCLES.
- Address decode:
  - off = addr - BASE_ADDR; idx = off >> log2(DATA_WIDTH/8).
  - In range iff addr >= BASE_ADDR and idx < DEPTH.
  - Low byte-offset bits are ignored: misaligned accesses hit the containing word and respond OKAY.
  - Out of range: the write is discarded with BRESP=SLVERR; the read returns RDATA=0 with RRESP=SLVERR.
- Simultaneous events:
  - Read and write to the same word with the write commit and the read sample on the same edge: the read returns the old data.
  - A write commit strictly earlier than the read sample is visible to the read.
  - VALID held by the master across multiple cycles while the slave is busy: no second capture; READY stays 0 until the FSM returns to idle.
  - BVALID/RVALID never drop without the matching READY (AXI rule), including when WAIT_CYCLES changes nothing.
- Reset mid-operation: any state returns to idle on the next edge, outputs go to reset values, and a half-captured AW/W pair is discarded.

Decomposition:
- Package axil_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_t, rd_state_t enums.
  - localparam helper for byte-offset bits.
- Sub-module axil_mem_array: DEPTH x DATA_WIDTH, one synchronous write port and one synchronous read port, no reset.

Test Plan:
- Write 32'hDEAD_BEEF to 0x10, then read 0x10 (WAIT_CYCLES=0) -> BVALID 1 cycle after W handshake, BRESP=00; RVALID 1 cycle after AR handshake, RDATA=32'hDEAD_BEEF, RRESP=00.
- W presented 3 cycles before AW, data 32'h1234_5678 to 0x04 -> WREADY drops after W capture, AW still accepted; one B response; read back 32'h1234_5678.
- Write and read at address 0x400 (idx 256, DEPTH=256) -> BRESP=10, RRESP=10, RDATA=0; word 0 unchanged.
- WAIT_CYCLES=3, BREADY/RREADY held low 5 cycles -> BVALID/RVALID rise 4 cycles after handshake and stay high with stable BRESP/RDATA until READY.
- Read and write to 0x08 with same-edge commit/sample (old value 32'hA5A5_A5A5, new 32'h5A5A_5A5A) -> read returns 32'hA5A5_A5A5; subsequent read returns 32'h5A5A_5A5A.
- rstn low for 1 cycle while in W_RESP and R_WAIT -> next cycle BVALID=RVALID=0; then AWREADY=WREADY=ARREADY=1; next write completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types and helpers for the AXI-Lite memory slave
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  localparam int WAIT_W = 4;

  function automatic int byte_off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_slave_mem_if.sv
// rtl/axil_slave_mem_if.sv - AXI-Lite five-channel bundle with master/slave views
interface axil_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] S_AXI_WDATA;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_mem_array.sv
// rtl/axil_mem_array.sv - word memory, one sync write port and one sync read port
module axil_mem_array #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Read samples the pre-write contents when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/axil_slave_mem.sv
// rtl/axil_slave_mem.sv - AXI-Lite memory target with independent read/write FSMs
module axil_slave_mem
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input logic        clk,
  input logic        rstn,
  axil_slave_mem_if.slave s_axi
);
  localparam int OFF_BITS = byte_off_bits(DATA_WIDTH);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> OFF_BITS) < ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_BITS);
  endfunction

  wr_state_t             r_wstate, w_wstate_nxt;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [WAIT_W-1:0]     r_wcnt;
  resp_t                 r_bresp;
  logic                  w_aw_hs, w_w_hs, w_wr_go, w_wr_ok;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  rd_state_t             r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [WAIT_W-1:0]     r_rcnt;
  logic                  r_rerr;
  logic                  w_ar_hs, w_rd_sample, w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // A channel beat landing this cycle is used directly so the commit needs no extra cycle.
  assign w_aw_hs   = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_w_hs    = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign w_wr_addr = r_aw_held ? r_awaddr : s_axi.S_AXI_AWADDR;
  assign w_wr_data = r_w_held ? r_wdata : s_axi.S_AXI_WDATA;
  assign w_wr_go   = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_ok   = in_range(w_wr_addr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_wcnt    <= '0;
      r_bresp   <= OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_wr_go) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_wcnt    <= WAIT_LD;
        r_bresp   <= w_wr_ok ? OKAY : SLVERR;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
        if (r_wstate == W_WAIT) r_wcnt <= r_wcnt - 1'b1;
      end
    end
    if (w_aw_hs) r_awaddr <= s_axi.S_AXI_AWADDR;
    if (w_w_hs)  r_wdata  <= s_axi.S_AXI_WDATA;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_go) w_wstate_nxt = (WAIT_CYCLES == 0) ? W_RESP : W_WAIT;
      W_WAIT:  if (r_wcnt == WAIT_W'(1)) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi.S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.S_AXI_AWREADY = rstn && (r_wstate == W_IDLE) && !r_aw_held;
    s_axi.S_AXI_WREADY  = rstn && (r_wstate == W_IDLE) && !r_w_held;
    s_axi.S_AXI_BVALID  = rstn && (r_wstate == W_RESP);
    s_axi.S_AXI_BRESP   = s_axi.S_AXI_BVALID ? r_bresp : OKAY;
  end

  assign w_ar_hs     = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign w_rd_addr   = (r_rstate == R_IDLE) ? s_axi.S_AXI_ARADDR : r_araddr;
  assign w_rd_sample = ((r_rstate == R_IDLE) && w_ar_hs && (WAIT_CYCLES == 0)) ||
                       ((r_rstate == R_WAIT) && (r_rcnt == WAIT_W'(1)));
  assign w_rd_ok     = in_range(w_rd_addr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) r_rcnt <= WAIT_LD;
      else if (r_rstate == R_WAIT) r_rcnt <= r_rcnt - 1'b1;
      if (w_rd_sample) r_rerr <= !w_rd_ok;
    end
    if (w_ar_hs) r_araddr <= s_axi.S_AXI_ARADDR;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = (WAIT_CYCLES == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_rcnt == WAIT_W'(1)) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.S_AXI_ARREADY = rstn && (r_rstate == R_IDLE);
    s_axi.S_AXI_RVALID  = rstn && (r_rstate == R_DATA);
    s_axi.S_AXI_RRESP   = (s_axi.S_AXI_RVALID && r_rerr) ? SLVERR : OKAY;
    s_axi.S_AXI_RDATA   = (s_axi.S_AXI_RVALID && !r_rerr) ? w_mem_rdata : '0;
  end

  axil_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_go && w_wr_ok),
    .i_waddr (word_idx(w_wr_addr)),
    .i_wdata (w_wr_data),
    .i_re    (w_rd_sample && w_rd_ok),
    .i_raddr (word_idx(w_rd_addr)),
    .o_rdata (w_mem_rdata)
  );
endmodule

// File: tb/tb_axil_slave_mem.sv
// tb/tb_axil_slave_mem.sv - randomized reference-model bench for axil_slave_mem
module tb_axil_slave_mem;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr [2], wdata [2], araddr [2];
  logic        awvalid [2], wvalid [2], bready [2], arvalid [2], rready [2];
  logic        awready [2], wready [2], bvalid [2], arready [2], rvalid [2];
  logic [1:0]  bresp [2], rresp [2];
  logic [31:0] rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axil_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    axil_slave_mem #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
      .BASE_ADDR(32'h0), .WAIT_CYCLES(g * 3)
    ) dut (
      .clk(clk), .rstn(rstn), .s_axi(bus.slave)
    );
    assign bus.S_AXI_AWADDR  = awaddr[g];
    assign bus.S_AXI_AWVALID = awvalid[g];
    assign bus.S_AXI_WDATA   = wdata[g];
    assign bus.S_AXI_WVALID  = wvalid[g];
    assign bus.S_AXI_BREADY  = bready[g];
    assign bus.S_AXI_ARADDR  = araddr[g];
    assign bus.S_AXI_ARVALID = arvalid[g];
    assign bus.S_AXI_RREADY  = rready[g];
    assign awready[g] = bus.S_AXI_AWREADY;
    assign wready[g]  = bus.S_AXI_WREADY;
    assign bvalid[g]  = bus.S_AXI_BVALID;
    assign bresp[g]   = bus.S_AXI_BRESP;
    assign arready[g] = bus.S_AXI_ARREADY;
    assign rvalid[g]  = bus.S_AXI_RVALID;
    assign rresp[g]   = bus.S_AXI_RRESP;
    assign rdata[g]   = bus.S_AXI_RDATA;
  end

  logic [31:0] model [2][256];
  bit          known [2][256];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic axi_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] exp_resp);
    int cyc = 0;
    int lat = 0;
    bit aw_done = 0;
    bit w_done = 0;
    logic [1:0] resp0;
    awaddr[d] = addr;
    wdata[d]  = data;
    while (!(aw_done && w_done) && cyc < 64) begin
      @(negedge clk);
      awvalid[d] = !aw_done && (cyc >= aw_dly);
      wvalid[d]  = !w_done && (cyc >= w_dly);
      if (w_done && !aw_done) check("wready_low_after_w", wready[d], 1'b0);
      if (awvalid[d] && awready[d]) aw_done = 1;
      if (wvalid[d] && wready[d]) w_done = 1;
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      check("aw_w_handshake_timeout", 1'b0, 1'b1);
      awvalid[d] = 0;
      wvalid[d]  = 0;
      return;
    end
    do begin
      @(negedge clk);
      awvalid[d] = 0;
      wvalid[d]  = 0;
      lat++;
    end while (!bvalid[d] && lat < 64);
    check("b_latency", lat, exp_lat(d));
    resp0 = bresp[d];
    check("bresp", resp0, exp_resp);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid[d], 1'b1);
      check("bresp_hold", bresp[d], resp0);
      check("awready_busy", awready[d], 1'b0);
    end
    bready[d] = 1;
    @(negedge clk);
    bready[d] = 0;
    check("bvalid_drop", bvalid[d], 1'b0);
    check("awready_back", awready[d], 1'b1);
  endtask

  task automatic axi_read(input int d, input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input bit chk_data, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int cyc = 0;
    int lat = 0;
    bit done = 0;
    logic [31:0] d0;
    araddr[d] = addr;
    while (!done && cyc < 64) begin
      @(negedge clk);
      arvalid[d] = (cyc >= ar_dly);
      if (arvalid[d] && arready[d]) done = 1;
      cyc++;
    end
    if (!done) begin
      check("ar_handshake_timeout", 1'b0, 1'b1);
      arvalid[d] = 0;
      return;
    end
    do begin
      @(negedge clk);
      arvalid[d] = 0;
      lat++;
    end while (!rvalid[d] && lat < 64);
    check("r_latency", lat, exp_lat(d));
    check("rresp", rresp[d], exp_resp);
    if (chk_data) check("rdata", rdata[d], exp_data);
    d0 = rdata[d];
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check("rvalid_hold", rvalid[d], 1'b1);
      check("rdata_hold", rdata[d], d0);
      check("arready_busy", arready[d], 1'b0);
    end
    rready[d] = 1;
    @(negedge clk);
    rready[d] = 0;
    check("rvalid_drop", rvalid[d], 1'b0);
    check("arready_back", arready[d], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, idx;
    logic [31:0] a, v;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = 0; wdata[i] = 0; araddr[i] = 0;
      awvalid[i] = 0; wvalid[i] = 0; bready[i] = 0; arvalid[i] = 0; rready[i] = 0;
      for (int j = 0; j < 256; j++) known[i][j] = 0;
    end

    rstn = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_awready", awready[i], 1'b0);
      check("rst_wready", wready[i], 1'b0);
      check("rst_arready", arready[i], 1'b0);
      check("rst_bvalid", bvalid[i], 1'b0);
      check("rst_rvalid", rvalid[i], 1'b0);
      check("rst_bresp", bresp[i], 2'b00);
      check("rst_rresp", rresp[i], 2'b00);
      check("rst_rdata", rdata[i], 32'h0);
    end
    rstn = 1;
    @(negedge clk);

    axi_write(0, 32'h00, 32'hCAFE_0000, 0, 0, 0, 2'b00);
    axi_write(0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 2'b00);
    axi_read(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 2'b00);
    axi_write(0, 32'h04, 32'h1234_5678, 3, 0, 0, 2'b00);
    axi_read(0, 32'h04, 0, 0, 1, 32'h1234_5678, 2'b00);
    axi_write(0, 32'h400, 32'hFFFF_FFFF, 0, 0, 0, 2'b10);
    axi_read(0, 32'h400, 0, 0, 1, 32'h0, 2'b10);
    axi_read(0, 32'hFFFF_FFFC, 1, 1, 1, 32'h0, 2'b10);
    axi_read(0, 32'h00, 0, 0, 1, 32'hCAFE_0000, 2'b00);
    axi_read(0, 32'h13, 0, 0, 1, 32'hDEAD_BEEF, 2'b00);
    model[0][0] = 32'hCAFE_0000;  known[0][0] = 1;
    model[0][1] = 32'h1234_5678;  known[0][1] = 1;
    model[0][4] = 32'hDEAD_BEEF;  known[0][4] = 1;

    axi_write(1, 32'h20, 32'h0BAD_F00D, 0, 1, 5, 2'b00);
    axi_read(1, 32'h20, 0, 5, 1, 32'h0BAD_F00D, 2'b00);
    model[1][8] = 32'h0BAD_F00D;  known[1][8] = 1;

    axi_write(0, 32'h08, 32'hA5A5_A5A5, 0, 0, 0, 2'b00);
    fork
      axi_write(0, 32'h08, 32'h5A5A_5A5A, 0, 0, 0, 2'b00);
      axi_read(0, 32'h08, 0, 0, 1, 32'hA5A5_A5A5, 2'b00);
    join
    axi_read(0, 32'h08, 0, 0, 1, 32'h5A5A_5A5A, 2'b00);
    model[0][2] = 32'h5A5A_5A5A;  known[0][2] = 1;

    @(negedge clk);
    awaddr[1] = 32'h30; wdata[1] = 32'h3030_3030; awvalid[1] = 1; wvalid[1] = 1;
    @(negedge clk);
    awvalid[1] = 0; wvalid[1] = 0;
    repeat (3) @(negedge clk);
    check("pre_reset_bvalid", bvalid[1], 1'b1);
    araddr[1] = 32'h30; arvalid[1] = 1;
    @(negedge clk);
    arvalid[1] = 0;
    check("pre_reset_rvalid", rvalid[1], 1'b0);
    rstn = 0;
    #1;
    check("rst_cycle_awready", awready[1], 1'b0);
    check("rst_cycle_bvalid", bvalid[1], 1'b0);
    @(negedge clk);
    rstn = 1;
    #1;
    check("post_rst_bvalid", bvalid[1], 1'b0);
    check("post_rst_rvalid", rvalid[1], 1'b0);
    check("post_rst_awready", awready[1], 1'b1);
    check("post_rst_wready", wready[1], 1'b1);
    check("post_rst_arready", arready[1], 1'b1);
    model[1][12] = 32'h3030_3030; known[1][12] = 1;
    axi_write(1, 32'h34, 32'h7777_1111, 0, 0, 0, 2'b00);
    axi_read(1, 32'h34, 0, 0, 1, 32'h7777_1111, 2'b00);
    model[1][13] = 32'h7777_1111; known[1][13] = 1;

    @(negedge clk);
    wdata[0] = 32'hBAD0_BAD0; wvalid[0] = 1;
    @(negedge clk);
    wvalid[0] = 0;
    check("half_w_wready", wready[0], 1'b0);
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    #1;
    check("half_w_discard", wready[0], 1'b1);
    axi_write(0, 32'h0C, 32'h600D_600D, 1, 0, 0, 2'b00);
    axi_read(0, 32'h0C, 0, 0, 1, 32'h600D_600D, 2'b00);
    model[0][3] = 32'h600D_600D; known[0][3] = 1;

    for (int n = 0; n < 120; n++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = $urandom_range(0, 1) ? 32'h400 + $urandom_range(0, 1023) : 32'hFFFF_F000 | $urandom_range(0, 4095);
      else
        a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      ok  = (a / 4) < 256;
      idx = ok ? int'(a / 4) : 0;
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom;
        axi_write(d, a, v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), ok ? 2'b00 : 2'b10);
        if (ok) begin
          model[d][idx] = v;
          known[d][idx] = 1;
        end
      end else begin
        axi_read(d, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 !ok || known[d][idx], ok ? model[d][idx] : 32'h0, ok ? 2'b00 : 2'b10);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
